// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions for the fetch stage: the opcodes that static
// prediction looks at, the J/B immediate extractors, the canonical NOP word
// and the fetch state encoding.
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0]  OP_JAL        = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH     = 7'b1100011;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Sign-extended J-type immediate, byte offset (bit 0 always 0).
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate, byte offset (bit 0 always 0).
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the fetch stage's instruction-memory read port, the redirect input
// from execute and the fetch->decode valid/ready channel.
//   master : the fetch stage
//   slave  : the environment (memory, execute, decode)
// Handshake: a fetch->decode transfer happens on a rising clk edge where
// if_valid and if_ready are both 1; while if_valid=1 and if_ready=0,
// if_pc/if_instr/if_pred_taken stay stable unless a redirect kills them.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_renable;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_pred_taken;

    modport master (
        output imem_addr, imem_renable, if_valid, if_pc, if_instr, if_pred_taken,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_addr, imem_renable, if_valid, if_pc, if_instr, if_pred_taken,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_static_pred.sv
// -----------------------------------------------------------------------------
// fetch_static_pred
// Static next-PC predictor: JAL is always taken, a conditional branch is taken
// when its offset is negative (backward loop). A target whose bit 1 is set is
// not word-aligned and falls back to pc+4, not taken.
// Ports:
//   instr_i  : fetched instruction word
//   pc_i     : PC of instr_i
//   target_o : predicted next PC
//   taken_o  : 1 when target_o is a predicted-taken target
// The module only exists when FETCH_STATIC_PRED_EN is defined, so the default
// build carries no immediate decode logic at all.
// -----------------------------------------------------------------------------
`ifdef FETCH_STATIC_PRED_EN
module fetch_static_pred
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] target_o,
    output logic        taken_o
);

    logic [31:0] imm;
    logic        hit;
    logic [31:0] sum;

    always_comb begin
        imm = 32'd0;
        hit = 1'b0;
        if (instr_i[6:0] == OP_JAL) begin
            imm = imm_j(instr_i);
            hit = 1'b1;
        end else if (instr_i[6:0] == OP_BRANCH && instr_i[31]) begin
            imm = imm_b(instr_i);
            hit = 1'b1;
        end
        sum = pc_i + imm;
        if (hit && !sum[1]) begin
            target_o = sum;
            taken_o  = 1'b1;
        end else begin
            target_o = pc_i + 32'd4;
            taken_o  = 1'b0;
        end
    end

endmodule
`endif

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Generates the PC stream, drives the instruction
// memory read port and presents each instruction with its PC to decode.
// Optional feature: define FETCH_STATIC_PRED_EN to enable static next-PC
// prediction (JAL and backward branches).
// Parameters:
//   RESET_PC  : first PC fetched after reset
//   NOP_INSTR : value of if_instr while if_valid=0
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   fetch_if    : memory port, redirect, fetch->decode channel (master side)
//   dbg_state_o : current FSM state
// -----------------------------------------------------------------------------
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        fetch_if,
    output fetch_state_e         dbg_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic         rst_dly_q;

    logic [31:0]  next_pc;
    logic         pred_raw;
    logic         in_reset;
    logic         valid;

    // The cycle after rst still shows reset values; BOOT issues its read
    // only once that settle cycle has passed.
    assign in_reset = rst | rst_dly_q;

`ifdef FETCH_STATIC_PRED_EN
    fetch_static_pred u_pred (
        .instr_i  (fetch_if.imem_rdata),
        .pc_i     (pc_q),
        .target_o (next_pc),
        .taken_o  (pred_raw)
    );
`else
    assign next_pc  = pc_q + 32'd4;
    assign pred_raw = 1'b0;
`endif

    assign valid       = !in_reset && state_q == ST_RUN && inflight_q && !fetch_if.redirect_valid;
    assign dbg_state_o = state_q;

    // State register
    always_ff @(posedge clk) begin
        rst_dly_q <= rst;
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        case (state_q)
            ST_BOOT: begin
                if (!rst_dly_q) begin
                    state_d    = ST_RUN;
                    pc_d       = RESET_PC;
                    inflight_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (fetch_if.redirect_valid) begin
                    pc_d       = fetch_if.redirect_pc;
                    inflight_d = 1'b1;
                end else if (!inflight_q) begin
                    // Nothing held: re-issue the read of pc_q.
                    inflight_d = 1'b1;
                end else if (fetch_if.if_ready) begin
                    pc_d = next_pc;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        fetch_if.imem_addr     = pc_q;
        fetch_if.imem_renable  = 1'b0;
        fetch_if.if_valid      = valid;
        fetch_if.if_pc         = pc_q;
        fetch_if.if_instr      = valid ? fetch_if.imem_rdata : NOP_INSTR;
        fetch_if.if_pred_taken = valid & pred_raw;
        if (in_reset) begin
            // pc_q may still hold a stale PC while rst is being sampled.
            fetch_if.imem_addr = RESET_PC;
            fetch_if.if_pc     = RESET_PC;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    fetch_if.imem_addr    = RESET_PC;
                    fetch_if.imem_renable = 1'b1;
                end
                ST_RUN: begin
                    if (fetch_if.redirect_valid) begin
                        fetch_if.imem_addr    = fetch_if.redirect_pc;
                        fetch_if.imem_renable = 1'b1;
                    end else if (!inflight_q) begin
                        fetch_if.imem_renable = 1'b1;
                    end else if (fetch_if.if_ready) begin
                        fetch_if.imem_addr    = next_pc;
                        fetch_if.imem_renable = 1'b1;
                    end
                    // Stall: renable stays 0 so memory holds rdata.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if wbus ();
  fetch_state_e  dbg_state;
  fetch_state_e  wdbg_state;

  instr_fetch #(.RESET_PC(RST_PC)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_if    (bus),
    .dbg_state_o (dbg_state)
  );

  instr_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .fetch_if    (wbus),
    .dbg_state_o (wdbg_state)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem_tbl [64];

  always @(posedge clk) begin
    if (bus.imem_renable)  bus.imem_rdata  <= mem_tbl[bus.imem_addr[7:2]];
    if (wbus.imem_renable) wbus.imem_rdata <= mem_tbl[wbus.imem_addr[7:2]];
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_tbl[a[7:2]];
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Next PC after the instruction at pc is accepted: {predicted_taken, next_pc}.
  function automatic logic [32:0] model_next(input logic [31:0] pc);
    logic [31:0] tgt;
    logic        tk;
    tgt = pc + 32'd4;
    tk  = 1'b0;
`ifdef FETCH_STATIC_PRED_EN
    begin
      logic [31:0] w;
      int          off;
      w   = mem_word(pc);
      off = 0;
      if (w[6:0] == 7'h6F) begin
        off = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        tk  = 1'b1;
      end else if (w[6:0] == 7'h63 && w[31]) begin
        off = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        tk  = 1'b1;
      end
      if (tk) begin
        tgt = pc + 32'(off);
        if (tgt[1]) begin
          tgt = pc + 32'd4;
          tk  = 1'b0;
        end
      end
    end
`endif
    return {tk, tgt};
  endfunction

  // Model: cycles since the last reset edge, and the PC decode should see.
  int          since = 0;
  logic [31:0] cur_pc = RST_PC;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      since   = 0;
      cur_pc  = RST_PC;
      started = 1'b1;
    end else if (started) begin
      if (since < 2) begin
        since  = since + 1;
        cur_pc = RST_PC;
      end else if (bus.redirect_valid) begin
        cur_pc = bus.redirect_pc;
      end else if (bus.if_ready) begin
        cur_pc = model_next(cur_pc)[31:0];
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic        e_valid, e_ren, e_pred;
    logic [31:0] e_pc, e_instr, e_addr;
    logic [32:0] nx;
    if (started) begin
      e_valid = 1'b0; e_ren = 1'b0; e_pred = 1'b0;
      e_pc = RST_PC; e_instr = NOP; e_addr = RST_PC;
      if (rst || since == 0) begin
        // reset values
      end else if (since == 1) begin
        e_ren = 1'b1;
      end else begin
        nx      = model_next(cur_pc);
        e_valid = !bus.redirect_valid;
        e_pc    = cur_pc;
        e_instr = e_valid ? mem_word(cur_pc) : NOP;
        e_pred  = e_valid & nx[32];
        if (bus.redirect_valid) begin
          e_ren = 1'b1; e_addr = bus.redirect_pc;
        end else if (!bus.if_ready) begin
          e_ren = 1'b0; e_addr = cur_pc;
        end else begin
          e_ren = 1'b1; e_addr = nx[31:0];
        end
      end
      chk1("if_valid", bus.if_valid, e_valid);
      chk ("if_pc", bus.if_pc, e_pc);
      chk ("if_instr", bus.if_instr, e_instr);
      chk1("if_pred_taken", bus.if_pred_taken, e_pred);
      chk1("imem_renable", bus.imem_renable, e_ren);
      if (e_ren) chk("imem_addr", bus.imem_addr, e_addr);
      if (!rst) chk1("dbg_state_run", dbg_state == ST_RUN, since >= 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'h6F;
      1: w[6:0] = 7'h63;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = 32'h0;
    wbus.if_ready       = 1'b1;
    for (int i = 0; i < 64; i++) mem_tbl[i] = {20'(i), 12'h013};
`ifdef FETCH_STATIC_PRED_EN
    mem_tbl[16] = 32'hFF1F_F06F;  // jal x0, -16 at 0x40
    mem_tbl[20] = 32'h0000_0463;  // beq x0, x0, +8 at 0x50 (forward)
`endif
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick(); tick();

    // Cycle after reset: reset values.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk1("post_rst_renable", bus.imem_renable, 1'b0);
    chk ("post_rst_addr", bus.imem_addr, 32'h0);
    chk ("post_rst_pc", bus.if_pc, 32'h0);
    chk ("post_rst_instr", bus.if_instr, 32'h0000_0013);
    chk ("wrap_post_rst_pc", wbus.if_pc, 32'hFFFF_FFFC);
    tick();
    // BOOT: read of RESET_PC.
    @(negedge clk);
    chk1("boot_renable", bus.imem_renable, 1'b1);
    chk1("boot_valid", bus.if_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("first_valid", bus.if_valid, 1'b1);
    chk ("first_pc", bus.if_pc, 32'h0);
    chk ("wrap_first_pc", wbus.if_pc, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk ("second_pc", bus.if_pc, 32'h4);
    chk ("wrap_second_pc", wbus.if_pc, 32'h0);
    chk1("wrap_second_valid", wbus.if_valid, 1'b1);
    tick();
    // pc=8: redirect to 0x100 with if_ready=1.
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    @(negedge clk);
    chk1("redir_kill_valid", bus.if_valid, 1'b0);
    chk ("redir_addr", bus.imem_addr, 32'h100);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk ("redir_pc", bus.if_pc, 32'h100);
    chk1("redir_valid", bus.if_valid, 1'b1);
    tick();
    // Back to 8, then redirect with if_ready=0.
    drive(1'b0, 1'b1, 32'h8, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    @(negedge clk);
    chk1("redir_stall_valid", bus.if_valid, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk ("redir_stall_pc", bus.if_pc, 32'h100);
    tick();
    // Back to 8, then stall for 3 cycles.
    drive(1'b0, 1'b1, 32'h8, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk ("stall_pc", bus.if_pc, 32'h8);
      chk ("stall_instr", bus.if_instr, 32'h0000_2013);
      chk1("stall_renable", bus.imem_renable, 1'b0);
      if (k < 2) tick();
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk ("release_pc", bus.if_pc, 32'h8);
    tick();
    @(negedge clk);
    chk ("after_release_pc", bus.if_pc, 32'hC);
    // Reset pulsed mid-stall.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk1("rst_mid_stall_valid", bus.if_valid, 1'b0);
    chk ("rst_mid_stall_pc", bus.if_pc, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick(); tick();
    @(negedge clk);
    chk ("restart_pc", bus.if_pc, 32'h0);
    chk1("restart_valid", bus.if_valid, 1'b1);
`ifdef FETCH_STATIC_PRED_EN
    tick();
    drive(1'b0, 1'b1, 32'h40, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk1("jal_pred", bus.if_pred_taken, 1'b1);
    tick();
    @(negedge clk);
    chk ("jal_target_pc", bus.if_pc, 32'h30);
    drive(1'b0, 1'b1, 32'h50, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk1("fwd_beq_pred", bus.if_pred_taken, 1'b0);
    tick();
    @(negedge clk);
    chk ("fwd_beq_next_pc", bus.if_pc, 32'h54);
`endif
    tick();

    // Randomized phase: new memory contents loaded while in reset.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 64; i++) mem_tbl[i] = rand_word();
    tick(); tick();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 7) == 0,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
